// File: rtl/signal_conflict_monitor.sv
// Intersection lamp-command monitor: passes controller commands to the lamps while checking
// encoding, conflicts, transition order, yellow length and stuck inputs; latches a fault and flashes red.
module signal_conflict_monitor #(
  parameter int unsigned MIN_YELLOW  = 3,
  parameter int unsigned WDOG_CYCLES = 32,
  parameter int unsigned FLASH_HALF  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north,
  input  logic [2:0] south,
  input  logic [2:0] east,
  input  logic [2:0] west,
  input  logic       fault_clr,
  output logic [2:0] north_lamp,
  output logic [2:0] south_lamp,
  output logic [2:0] east_lamp,
  output logic [2:0] west_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [2:0] Red = 3'b100;
  localparam logic [2:0] Yel = 3'b010;
  localparam logic [2:0] Grn = 3'b001;

  localparam int unsigned YW = (MIN_YELLOW > 1) ? $clog2(MIN_YELLOW + 1) : 1;
  localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam int unsigned FW = (FLASH_HALF > 2) ? $clog2(FLASH_HALF) : 1;

  logic [2:0]    cur      [4];
  logic [2:0]    prev_q   [4];
  logic [2:0]    prev_d   [4];
  logic [2:0]    lamp_q   [4];
  logic [2:0]    lamp_d   [4];
  logic [YW-1:0] ycnt_q   [4];
  logic [YW-1:0] ycnt_d   [4];
  logic [YW-1:0] ycnt_inc [4];
  logic [WW-1:0] wd_q, wd_d, wd_inc;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fault_q, fault_d;
  logic [2:0]    code_q, code_d;
  logic          flash_q, flash_d;

  logic          v_inv, v_cfl, v_ill, v_short, v_wd, same;
  logic [2:0]    n_act;
  logic [2:0]    v_code;

  assign cur[0] = north;
  assign cur[1] = south;
  assign cur[2] = east;
  assign cur[3] = west;

  // Violation detection against the previous sample
  always_comb begin
    v_inv   = 1'b0;
    v_ill   = 1'b0;
    v_short = 1'b0;
    same    = 1'b1;
    n_act   = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ycnt_inc[i] = '0;
      if (cur[i] != Red && cur[i] != Yel && cur[i] != Grn) v_inv = 1'b1;
      if (cur[i][1:0] != 2'b00) n_act = n_act + 3'd1;
      if (cur[i] != prev_q[i]) begin
        same = 1'b0;
        if (!((prev_q[i] == Red && cur[i] == Grn) ||
              (prev_q[i] == Grn && cur[i] == Yel) ||
              (prev_q[i] == Yel && cur[i] == Red))) begin
          v_ill = 1'b1;
        end
        if (prev_q[i] == Yel && cur[i] == Red && ycnt_q[i] < YW'(MIN_YELLOW)) v_short = 1'b1;
      end
      if (cur[i] == Yel) begin
        ycnt_inc[i] = (ycnt_q[i] == YW'(MIN_YELLOW)) ? ycnt_q[i] : ycnt_q[i] + 1'b1;
      end
    end
    v_cfl  = (n_act > 3'd1);
    wd_inc = '0;
    if (same) wd_inc = (wd_q == WW'(WDOG_CYCLES)) ? wd_q : wd_q + 1'b1;
    v_wd   = same && (wd_inc >= WW'(WDOG_CYCLES));

    if (v_inv)        v_code = 3'd1;
    else if (v_cfl)   v_code = 3'd2;
    else if (v_ill)   v_code = 3'd3;
    else if (v_short) v_code = 3'd4;
    else if (v_wd)    v_code = 3'd5;
    else              v_code = 3'd0;
  end

  always_comb begin
    prev_d  = cur;
    lamp_d  = cur;
    ycnt_d  = ycnt_q;
    wd_d    = wd_q;
    fault_d = fault_q;
    code_d  = code_q;
    flash_d = flash_q;
    fcnt_d  = fcnt_q;
    if (!fault_q) begin
      ycnt_d = ycnt_inc;
      wd_d   = wd_inc;
      if (v_code != 3'd0) begin
        fault_d = 1'b1;
        code_d  = v_code;
        flash_d = 1'b1;
        fcnt_d  = '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) lamp_d[i] = {flash_q, 2'b00};
      if (fcnt_q == FW'(FLASH_HALF - 1)) begin
        flash_d = ~flash_q;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
      // Recovery is refused while the controller still commands a malformed or conflicting state
      if (fault_clr && !v_inv && !v_cfl) begin
        fault_d = 1'b0;
        code_d  = 3'd0;
        wd_d    = '0;
        flash_d = 1'b0;
        fcnt_d  = '0;
        for (int i = 0; i < 4; i++) ycnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        prev_q[i] <= Red;
        lamp_q[i] <= Red;
        ycnt_q[i] <= '0;
      end
      wd_q    <= '0;
      fcnt_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      flash_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      lamp_q  <= lamp_d;
      ycnt_q  <= ycnt_d;
      wd_q    <= wd_d;
      fcnt_q  <= fcnt_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      flash_q <= flash_d;
    end
  end

  assign north_lamp = lamp_q[0];
  assign south_lamp = lamp_q[1];
  assign east_lamp  = lamp_q[2];
  assign west_lamp  = lamp_q[3];
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule
